// File: rtl/ternary_neuron_accum.sv
// ternary_neuron_accum: sums saturated (pos - neg) popcounts per neuron and emits a thresholded ternary activation
module ternary_neuron_accum #(
    parameter int PC_W      = 5,
    parameter int ACC_W     = 10,
    parameter int MAX_BEATS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PC_W-1:0]         in_pc_pos,
    input  logic [PC_W-1:0]         in_pc_neg,
    input  logic                    in_last,
    input  logic signed [ACC_W-1:0] thr_hi,
    input  logic signed [ACC_W-1:0] thr_lo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_act,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_flag
);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic signed [ACC_W:0] L_MAX = (ACC_W + 1)'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W:0] L_MIN = -L_MAX;
    typedef enum logic {S_ACC, S_OUT} state_t;
    state_t                  r_state, w_state_nxt;
    logic signed [ACC_W-1:0] r_acc, w_d, w_sat;
    logic signed [ACC_W:0]   w_wide;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_flag_acc, w_accept, w_forced, w_close, w_clamp_hi, w_clamp_lo;
    logic [1:0]              w_act;
    assign w_d        = $signed({{(ACC_W - PC_W){1'b0}}, in_pc_pos}) - $signed({{(ACC_W - PC_W){1'b0}}, in_pc_neg});
    assign w_wide     = {r_acc[ACC_W-1], r_acc} + {w_d[ACC_W-1], w_d};
    assign w_clamp_hi = w_wide > L_MAX;
    assign w_clamp_lo = w_wide < L_MIN;
    assign w_sat      = w_clamp_hi ? L_MAX[ACC_W-1:0] : w_clamp_lo ? L_MIN[ACC_W-1:0] : w_wide[ACC_W-1:0];
    assign w_act      = (w_sat >= thr_hi) ? 2'b01 : (w_sat <= thr_lo) ? 2'b11 : 2'b00;
    assign w_accept   = in_valid & (r_state == S_ACC);
    assign w_forced   = r_cnt == CNT_W'(MAX_BEATS - 1);
    assign w_close    = w_accept & (in_last | w_forced);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_ACC;
        else        r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        if (r_state == S_ACC) begin
            in_ready    = 1'b1;
            w_state_nxt = w_close ? S_OUT : S_ACC;
        end else begin
            out_valid   = 1'b1;
            w_state_nxt = out_ready ? S_ACC : S_OUT;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_flag_acc <= 1'b0;
            out_sum    <= '0;
            out_act    <= 2'b00;
            out_flag   <= 1'b0;
        end else if (w_close) begin
            out_sum    <= w_sat;
            out_act    <= w_act;
            out_flag   <= r_flag_acc | w_clamp_hi | w_clamp_lo | w_forced;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_flag_acc <= 1'b0;
        end else if (w_accept) begin
            r_acc      <= w_sat;
            r_cnt      <= r_cnt + CNT_W'(1);
            r_flag_acc <= r_flag_acc | w_clamp_hi | w_clamp_lo;
        end
    end
endmodule
